// File: rtl/ita_package.sv
// ita_package: shared ITA dimensions, step encoding and mask-apply types.
package ita_package;

    localparam int N  = 16;
    localparam int M  = 64;
    localparam int WO = 8;

    typedef enum logic [2:0] {Idle, Q, K, V, QK, AV, OW} step_e;

    typedef struct packed {
        step_e step;
        logic  calc_en;
    } ctrl_t;

    // Lane value that drives a masked score to zero weight after softmax
    localparam logic signed [WO-1:0] MaskFillValue = {1'b1, {(WO-1){1'b0}}};

    typedef struct packed {
        logic          all_masked;
        logic [N*WO-1:0] data;
    } beat_t;

endpackage

// File: rtl/ita_mask_fifo.sv
// ita_mask_fifo: pending-mask FIFO; full pushes are dropped unless a pop frees a slot.
module ita_mask_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full_o  = count_o == (AW+1)'(DEPTH);
    assign empty_o = count_o == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count_o <= count_o + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ita_mask_apply.sv
// ita_mask_apply: applies generator masks to QK results in calc order, through a 2-entry skid buffer.
module ita_mask_apply
    import ita_package::*;
#(
    parameter int MASK_FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  step_e           step_i,
    input  logic            calc_en_i,
    input  logic [N-1:0]    mask_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [N*WO-1:0] data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [N*WO-1:0] data_o,
    output logic            all_masked_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam int CW = $clog2(MASK_FIFO_DEPTH) + 1;

    logic            is_qk, cap_q, init_q, qk_beat, bypass, push;
    logic            fifo_full, fifo_empty, in_fire, out_fire;
    logic [N-1:0]    fifo_mask, sel_mask;
    logic [CW-1:0]   fifo_count;
    logic [N*WO-1:0] masked;
    logic [1:0]      cnt_q;
    beat_t           in_beat;
    beat_t           skid_q [2];

    // cap_q marks that mask_i carries the mask of last cycle's QK calc
    assign is_qk    = step_i == QK;
    assign qk_beat  = is_qk && valid_i && ready_o;
    assign bypass   = qk_beat && fifo_empty && cap_q;
    assign push     = cap_q && is_qk && !bypass;
    assign sel_mask = !is_qk ? '0 : !fifo_empty ? fifo_mask : cap_q ? mask_i : '0;

    ita_mask_fifo #(.DEPTH(MASK_FIFO_DEPTH), .WIDTH(N)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (!is_qk),
        .push_i  (push),
        .pop_i   (qk_beat),
        .data_i  (mask_i),
        .data_o  (fifo_mask),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_empty == (fifo_count == '0));

    always_comb begin
        masked = data_i;
        for (int l = 0; l < N; l++) if (sel_mask[l]) masked[l*WO +: WO] = MaskFillValue;
    end

    assign in_beat      = '{all_masked: is_qk && (&sel_mask), data: masked};
    assign ready_o      = init_q && cnt_q != 2'd2;
    assign valid_o      = cnt_q != '0;
    assign in_fire      = valid_i && ready_o;
    assign out_fire     = valid_o && ready_i;
    assign data_o       = skid_q[0].data;
    assign all_masked_o = skid_q[0].all_masked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q       <= 1'b0;
            init_q      <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            cap_q       <= calc_en_i && is_qk;
            init_q      <= 1'b1;
            overflow_o  <= overflow_o | (push && fifo_full && !qk_beat);
            underflow_o <= underflow_o | (qk_beat && fifo_empty && !cap_q);
        end
    end

    // Head entry drives the outputs and only moves on a pop or when empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            if (in_fire && (cnt_q == 2'd0 || (cnt_q == 2'd1 && out_fire))) skid_q[0] <= in_beat;
            else if (out_fire) skid_q[0] <= skid_q[1];
            if (in_fire && cnt_q == 2'd1 && !out_fire) skid_q[1] <= in_beat;
            cnt_q <= cnt_q + 2'(in_fire) - 2'(out_fire);
        end
    end

endmodule

// File: tb/tb_ita_mask_apply.sv
// tb_ita_mask_apply: directed vectors with a queue scoreboard checked by an output monitor.
module tb_ita_mask_apply;
    import ita_package::*;

    localparam int W = N*WO;
    localparam logic [W-1:0] RAMP = 128'h8F7E6D5C4B3A29180706F5E4D3C2B1A0;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    step_e        step_i = Idle;
    logic         calc_en_i = 1'b0;
    logic [N-1:0] mask_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] data_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] data_o;
    logic         all_masked_o, overflow_o, underflow_o;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q [$];
    logic [N-1:0] m33 [4] = '{16'h0001, 16'h00F0, 16'h8000, 16'hFFFF};
    logic [N-1:0] m34 [5] = '{16'h0003, 16'h0030, 16'h0300, 16'h3000, 16'h7777};

    always #5 clk_i = ~clk_i;

    ita_mask_apply #(.MASK_FIFO_DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .step_i       (step_i),
        .calc_en_i    (calc_en_i),
        .mask_i       (mask_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .all_masked_o (all_masked_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] fill(input logic [WO-1:0] v);
        return {N{v}};
    endfunction

    function automatic logic [W-1:0] apply(input logic [N-1:0] m, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        for (int l = 0; l < N; l++) if (m[l]) r[l*WO +: WO] = 8'h80;
        return r;
    endfunction

    // Mask generator model: mask_i follows its calc_en_i cycle by one cycle
    task automatic calc(input logic [N-1:0] m);
        calc_en_i = 1'b1;
        tick;
        calc_en_i = 1'b0;
        mask_i = m;
        tick;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] ed, input logic ea);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i = d;
        while (!ready_o && n < 50) begin
            tick;
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready_o=0 after %0d cycles expected 1", n);
        end else begin
            exp_q.push_back({ea, ed});
        end
        tick;
        valid_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected no beat", {all_masked_o, data_o});
            end else begin
                chk("beat", {all_masked_o, data_o}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", W'(ready_o), 0);
        chk("rst_valid", W'(valid_o), 0);
        chk("rst_out", {all_masked_o, data_o}, 0);
        chk("rst_flags", {overflow_o, underflow_o}, 0);
        rst_ni = 1'b1;
        tick;
        chk("ready_after_rst", W'(ready_o), 1);
        step_i = QK;
        tick;

        calc(16'h00FF);
        send(fill(8'h05), {{8{8'h05}}, {8{8'h80}}}, 1'b0);
        chk("latency_valid", W'(valid_o), 1);

        calc(16'hFFFF);
        send(fill(8'h05), fill(8'h80), 1'b1);
        step_i = AV;
        send(fill(8'h05), fill(8'h05), 1'b0);

        step_i = QK;
        tick;
        chk("underflow_before", W'(underflow_o), 0);
        send(fill(8'h33), fill(8'h33), 1'b0);
        chk("underflow_set", W'(underflow_o), 1);

        for (int i = 0; i < 4; i++) calc(m33[i]);
        ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(RAMP ^ fill(8'(i*17)), apply(m33[i], RAMP ^ fill(8'(i*17))), i == 3);
                    tick;
                end
            end
            begin
                repeat (10) tick;
                chk("stall_hold", {valid_o, data_o}, {1'b1, apply(16'h0001, RAMP)});
                chk("stall_allm", W'(all_masked_o), 0);
                ready_i = 1'b1;
            end
        join

        step_i = AV;
        tick;
        step_i = QK;
        tick;
        chk("overflow_before", W'(overflow_o), 0);
        for (int i = 0; i < 5; i++) calc(m34[i]);
        chk("overflow_set", W'(overflow_o), 1);
        for (int i = 0; i < 4; i++) send(fill(8'(i+1)), apply(m34[i], fill(8'(i+1))), 1'b0);
        send(fill(8'h55), fill(8'h55), 1'b0);

        calc(16'h000F);
        calc(16'h00F0);
        ready_i = 1'b0;
        send(fill(8'h22), apply(16'h000F, fill(8'h22)), 1'b0);
        tick;
        chk("held_before_rst", W'(valid_o), 1);
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_valid", W'(valid_o), 0);
        chk("rst_mid_flags", {overflow_o, underflow_o}, 0);
        tick;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        tick;
        calc(16'h0F0F);
        send(fill(8'h44), apply(16'h0F0F, fill(8'h44)), 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending beats expected 0", exp_q.size());
        end
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ita_mask_apply.md
ITA_MASK_APPLY -- requirements
Module: ita_mask_apply

Interface
REQ-001 SHALL have parameter MASK_FIFO_DEPTH, default 4, depth of pending-mask FIFO (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port step_i  input  step_e  current ITA step; masking applies only when QK.
REQ-005 SHALL have port calc_en_i  input  1  same calc-enable driving the mask generator; a mask word is produced for every QK calc_en_i cycle.
REQ-006 SHALL have port mask_i  input  N  registered mask from mask generator, valid the cycle after calc_en_i; bit i=1 means lane i masked.
REQ-007 SHALL have port valid_i  input  1  upstream requantized-result valid.
REQ-008 SHALL have port ready_o  output  1  upstream backpressure.
REQ-009 SHALL have port data_i  input  N*WO  N signed WO-bit lanes.
REQ-010 SHALL have port valid_o  input-side counterpart: output  1  result valid to softmax.
REQ-011 SHALL have port ready_i  input  1  softmax backpressure.
REQ-012 SHALL have port data_o  output  N*WO  masked lanes.
REQ-013 SHALL have port all_masked_o  output  1  qualifies data_o: every lane masked.
REQ-014 SHALL have port overflow_o  output  1  sticky: mask arrived with FIFO full.
REQ-015 SHALL have port underflow_o  output  1  sticky: QK data arrived with FIFO empty.

Function
REQ-016 SHALL capture mask_i into the FIFO in cycle t+1 when calc_en_i=1 and step_i==QK in cycle t (1-cycle capture pipeline register).
REQ-017 SHALL pop one mask entry per accepted (valid_i && ready_o) beat while step_i==QK; other steps pass data through unchanged with all_masked_o=0 and no pop.
REQ-018 SHALL replace each masked lane with the most negative WO-bit value (-2^(WO-1)); unmasked lanes pass bit-exact.
REQ-019 SHALL assert all_masked_o iff popped mask equals all-ones.
REQ-020 SHALL register output through a 2-entry skid buffer: data appears on data_o one cycle after acceptance; ready_o=1 whenever skid has a free entry, so full throughput with ready_i=1 and no combinational ready_i->ready_o path.
REQ-021 SHALL hold data_o/valid_o/all_masked_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL, on simultaneous push and pop, keep occupancy unchanged; pop on empty FIFO is allowed only as a bypass when the capture register holds a mask that same cycle, else QK beat uses mask '0 and sets underflow_o.
REQ-023 SHALL drop a push with FIFO full (unless simultaneous pop) and set overflow_o.
REQ-024 SHALL wrap FIFO pointers modulo MASK_FIFO_DEPTH; occupancy counter width clog2(depth)+1.
REQ-025 SHALL flush FIFO and capture register when step_i transitions away from QK; sticky flags clear only on reset.
REQ-026 SHALL ensure masked beats cannot be reordered relative to masks: FIFO order equals calc order.

Reset
REQ-027 SHALL, on rst_ni low, asynchronously clear FIFO, pointers, occupancy, capture register, skid buffer; valid_o=0, data_o='0, all_masked_o=0, overflow_o=0, underflow_o=0, ready_o=0 during reset, 1 the first cycle after release.
REQ-028 SHALL discard in-flight beats and masks on reset mid-operation; no partial beat emitted after release.

Structure
REQ-029 SHALL take N, M, WO, step_e, ctrl_t from ita_package; add MaskFillValue (-2^(WO-1)) constant there.
REQ-030 SHALL implement the mask FIFO as one sub-module, ita_mask_fifo (push/pop/full/empty/count).

Verification
REQ-031 Mask 16'h00FF at QK, data all +5 -> data_o lanes 0-7 = -128, lanes 8-15 = 5, all_masked_o=0, one cycle after acceptance.
REQ-032 Mask 16'hFFFF -> all lanes -128, all_masked_o=1; step AV with same data -> unchanged, all_masked_o=0.
REQ-033 Four calc_en_i cycles then ready_i=0 for 10 cycles, data trickled in -> output order matches mask order, data_o stable, no loss.
REQ-034 Five masks pushed with no pops (depth 4) -> overflow_o=1, first four masks applied in order.
REQ-035 QK valid_i with FIFO and capture empty -> underflow_o=1, data passed unmasked.
REQ-036 rst_ni low mid-stream with 2 masks queued -> valid_o=0 immediately, next beat after release uses fresh mask.
